// File: rtl/mem_line_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writes onto the single
// 128-bit line memory, one transaction at a time with alternating priority.
module mem_line_arbiter #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_rd_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_done,
    output logic [LINE_W-1:0] d_rd_data,
    input  logic              flush,
    input  logic              loading,
    output logic              mem_requested,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wr_data,
    output logic              mem_reset_mem_req,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rd_data
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 1 = dcache owns the transaction
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rd_q, i_rd_d;
    logic [LINE_W-1:0] d_rd_q, d_rd_d;
    logic              grant_d;
    logic              in_flight;
    logic              abort;

    assign in_flight = (state_q == S_ISSUE) || (state_q == S_BUSY) || (state_q == S_DRAIN);
    assign abort     = flush && in_flight;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rd_q       <= '0;
            d_rd_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rd_q       <= i_rd_d;
            d_rd_q       <= d_rd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rd_d       = i_rd_q;
        d_rd_d       = d_rd_q;
        grant_d      = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!loading && !flush && (i_req || d_req)) begin
                        // Tie goes to whichever port was not granted last.
                        grant_d      = d_req && (!i_req || !last_grant_q);
                        owner_d      = grant_d;
                        last_grant_d = grant_d;
                        addr_d       = grant_d ? d_addr : i_addr;
                        we_d         = grant_d && d_we;
                        wdata_d      = grant_d ? d_wr_data : '0;
                        state_d      = S_ISSUE;
                    end
                end
                S_ISSUE: if (mem_ready) state_d = S_BUSY;
                S_BUSY:  if (mem_ready) state_d = S_DRAIN;
                S_DRAIN: begin
                    if (!we_q) begin
                        if (owner_q) d_rd_d = mem_rd_data;
                        else         i_rd_d = mem_rd_data;
                    end
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_requested     = 1'b0;
        mem_we            = 1'b0;
        mem_reset_mem_req = 1'b0;
        i_done            = 1'b0;
        d_done            = 1'b0;
        if (reset) begin
            // Memory may be mid-operation; restart it along with us.
            mem_reset_mem_req = (state_q != S_IDLE);
        end else if (abort) begin
            mem_reset_mem_req = 1'b1;
        end else begin
            case (state_q)
                S_ISSUE: begin
                    mem_requested = 1'b1;
                    mem_we        = we_q;
                end
                S_BUSY: begin
                    // Drop request the cycle ready returns so memory does not restart.
                    mem_requested = !mem_ready;
                    mem_we        = we_q;
                end
                S_DONE: begin
                    i_done = !owner_q;
                    d_done = owner_q;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;
    assign i_rd_data   = i_rd_q;
    assign d_rd_data   = d_rd_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a behavioural 5-cycle line memory.
module tb_mem_line_arbiter;

    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;
    localparam logic [LINE_W-1:0] L10  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [LINE_W-1:0] L100 = {4{32'h55555555}};
    localparam logic [LINE_W-1:0] WDAT = 128'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, d_req, d_we, flush, loading;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wr_data;
    logic              i_done, d_done;
    logic [LINE_W-1:0] i_rd_data, d_rd_data;
    logic              mem_requested, mem_we, mem_reset_mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wr_data, mem_rd_data;
    logic              mem_ready;

    int n_chk = 0;
    int n_err = 0;
    int req_cyc, we_cyc;

    always #5 clk = ~clk;

    mem_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rd_data(i_rd_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
        .d_done(d_done), .d_rd_data(d_rd_data),
        .flush(flush), .loading(loading),
        .mem_requested(mem_requested), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_reset_mem_req(mem_reset_mem_req),
        .mem_ready(mem_ready), .mem_rd_data(mem_rd_data)
    );

    // Memory model: accepts when idle and requested, ready returns after 5 busy cycles.
    logic [LINE_W-1:0] mem_arr [logic [ADDR_W-1:0]];
    logic              m_busy = 1'b0;
    logic              m_we;
    logic [2:0]        m_cnt;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wd;

    initial begin
        mem_ready   = 1'b1;
        mem_rd_data = '0;
        mem_arr[20'h00010] = L10;
        mem_arr[20'h00100] = L100;
    end

    always @(posedge clk) begin
        if (mem_reset_mem_req) begin
            m_busy    <= 1'b0;
            mem_ready <= 1'b1;
        end else if (!m_busy && mem_requested) begin
            m_busy    <= 1'b1;
            mem_ready <= 1'b0;
            m_cnt     <= 3'd0;
            m_addr    <= mem_addr;
            m_we      <= mem_we;
            m_wd      <= mem_wr_data;
        end else if (m_busy) begin
            if (m_cnt == 3'd4) begin
                m_busy    <= 1'b0;
                mem_ready <= 1'b1;
                if (m_we) mem_arr[m_addr] = m_wd;
                else mem_rd_data <= mem_arr.exists(m_addr) ? mem_arr[m_addr] : '0;
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for a done pulse (bounded), then drops the owner's request on the next edge.
    task automatic wait_done(output int lat, output logic who);
        lat = -1;
        who = 1'b0;
        req_cyc = 0;
        we_cyc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mem_requested) req_cyc++;
            if (mem_we) we_cyc++;
            if (i_done || d_done) begin
                lat = n;
                who = d_done;
                break;
            end
        end
        @(posedge clk); #1;
        if (lat >= 0) begin
            if (who) d_req = 1'b0;
            else     i_req = 1'b0;
        end
    endtask

    initial begin
        int   lat;
        logic who;
        int   cnt;
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; flush = 0; loading = 0;
        i_addr = 20'h00010; d_addr = 20'h00100; d_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 128'({i_done, d_done, mem_requested, mem_we, mem_reset_mem_req}), '0);
        chk("rst_data", i_rd_data | d_rd_data | mem_wr_data | 128'(mem_addr), '0);
        @(posedge clk); #1;

        // Alternating priority on repeated ties
        for (int r = 0; r < 2; r++) begin
            i_req = 1'b1; d_req = 1'b1;
            wait_done(lat, who);
            chk("tie_first_d", 128'(who), 128'd1);
            chk("tie_d_data", d_rd_data, L100);
            wait_done(lat, who);
            chk("tie_second_i", 128'(who), 128'd0);
            chk("tie_i_data", i_rd_data, L10);
        end

        // Single icache read from idle memory
        i_req = 1'b1;
        wait_done(lat, who);
        chk("i_lat", 128'(lat), 128'd9);
        chk("i_who", 128'(who), 128'd0);
        chk("i_req_cycles", 128'(req_cyc), 128'd6);
        chk("i_data", i_rd_data, L10);

        // Line write, then read back
        d_we = 1'b1; d_wr_data = WDAT; d_req = 1'b1;
        wait_done(lat, who);
        chk("w_lat", 128'(lat), 128'd9);
        chk("w_who", 128'(who), 128'd1);
        chk("w_we_cycles", 128'(we_cyc), 128'd7);
        chk("w_rd_hold", d_rd_data, L100);
        d_we = 1'b0; d_req = 1'b1;
        wait_done(lat, who);
        chk("rb_lat", 128'(lat), 128'd9);
        chk("rb_data", d_rd_data, WDAT);
        chk("rb_i_hold", i_rd_data, L10);

        // Flush in the third BUSY cycle
        i_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("fl_pulse", 128'(mem_reset_mem_req), 128'd1);
        chk("fl_req_low", 128'(mem_requested), 128'd0);
        @(posedge clk); #1;
        flush = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("fl_idle", 128'({mem_reset_mem_req, mem_requested}), '0);
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (i_done || d_done) cnt++;
        end
        chk("fl_no_done", 128'(cnt), '0);
        chk("fl_rd_hold", d_rd_data, WDAT);
        @(posedge clk); #1;
        i_req = 1'b1;
        wait_done(lat, who);
        chk("fl_retry_lat", 128'(lat), 128'd9);
        chk("fl_retry_data", i_rd_data, L10);

        // Loading holds off grants
        loading = 1'b1; i_req = 1'b1;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_requested || i_done) cnt++;
            if (n < 5) begin @(posedge clk); #1; end
        end
        chk("ld_blocked", 128'(cnt), '0);
        @(posedge clk); #1;
        loading = 1'b0;
        wait_done(lat, who);
        chk("ld_lat", 128'(lat), 128'd9);

        // Reset in the middle of BUSY
        d_req = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mr_mem_reset", 128'(mem_reset_mem_req), 128'd1);
        @(posedge clk); #1;
        reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("mr_ctl", 128'({i_done, d_done, mem_requested, mem_we, mem_reset_mem_req}), '0);
        chk("mr_data", i_rd_data | d_rd_data | mem_wr_data | 128'(mem_addr), '0);
        @(posedge clk); #1;
        i_req = 1'b1; d_req = 1'b1;
        wait_done(lat, who);
        chk("mr_tie_d", 128'(who), 128'd1);
        wait_done(lat, who);
        chk("mr_tie_i", 128'(who), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
